// File: rtl/psram_init_seq.sv
// PSRAM power-up sequencer: power-up delay, then RSTEN, RST and an optional
// Enter-QPI, each sent as an SPI command with sclk at clk/2.
module psram_init_seq #(
  parameter int CLK_FREQ_MHZ = 84,
  parameter int PWRUP_US     = 150,
  parameter int GAP_CYCLES   = 4,
  parameter int ENTER_QPI    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       mem_ce,
  output logic       mem_sclk,
  output logic [3:0] mem_sio_out,
  output logic [3:0] mem_sio_oe,
  output logic       busy,
  output logic       done,
  output logic [3:0] step
);

  localparam int DELAY_CYCLES = CLK_FREQ_MHZ * PWRUP_US;
  localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DELAY_CYCLES - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    DELAY = 4'd1,
    RSTEN = 4'd2,
    GAP1  = 4'd3,
    RST   = 4'd4,
    GAP2  = 4'd5,
    QPI   = 4'd6,
    GAP3  = 4'd7,
    DONE  = 4'd8
  } state_t;

  state_t        state, state_nx;
  logic          lat, lat_nx;
  logic [DW-1:0] dcnt, dcnt_nx;
  logic [3:0]    k, k_nx;
  logic [GW-1:0] gcnt, gcnt_nx;

  logic          is_cmd;
  logic [7:0]    cmd;

  always_comb begin
    state_nx = state;
    lat_nx   = lat;
    dcnt_nx  = dcnt;
    k_nx     = k;
    gcnt_nx  = gcnt;
    unique case (state)
      IDLE: begin
        if (lat)
          state_nx = DELAY;
        else if (start)
          lat_nx = 1'b1;
      end
      DELAY: begin
        if (dcnt == DLAST) begin
          dcnt_nx  = '0;
          state_nx = RSTEN;
        end else begin
          dcnt_nx = dcnt + 1'b1;
        end
      end
      RSTEN, RST, QPI: begin
        // k wraps to 0 on the last phase, so it is clear on exit
        k_nx = k + 4'd1;
        if (k == 4'd15) begin
          if (state == RSTEN)
            state_nx = GAP1;
          else if (state == RST)
            state_nx = GAP2;
          else
            state_nx = GAP3;
        end
      end
      GAP1, GAP2, GAP3: begin
        if (gcnt == GLAST) begin
          gcnt_nx = '0;
          if (state == GAP1)
            state_nx = RST;
          else if (state == GAP2 && ENTER_QPI != 0)
            state_nx = QPI;
          else
            state_nx = DONE;
        end else begin
          gcnt_nx = gcnt + 1'b1;
        end
      end
      DONE: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values and then flopped
  always_comb begin
    is_cmd = 1'b0;
    cmd    = 8'h00;
    unique case (state_nx)
      RSTEN: begin
        is_cmd = 1'b1;
        cmd    = 8'h66;
      end
      RST: begin
        is_cmd = 1'b1;
        cmd    = 8'h99;
      end
      QPI: begin
        is_cmd = 1'b1;
        cmd    = 8'h35;
      end
      default: begin
        is_cmd = 1'b0;
        cmd    = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lat   <= 1'b0;
      dcnt  <= '0;
      k     <= '0;
      gcnt  <= '0;
    end else begin
      state <= state_nx;
      lat   <= lat_nx;
      dcnt  <= dcnt_nx;
      k     <= k_nx;
      gcnt  <= gcnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ce      <= 1'b1;
      mem_sclk    <= 1'b0;
      mem_sio_out <= 4'b0000;
      mem_sio_oe  <= 4'b0000;
      busy        <= 1'b0;
      done        <= 1'b0;
      step        <= 4'd0;
    end else begin
      mem_ce      <= ~is_cmd;
      mem_sclk    <= is_cmd & k_nx[0];
      mem_sio_out <= {3'b000, is_cmd & cmd[~k_nx[3:1]]};
      mem_sio_oe  <= {3'b000, is_cmd};
      busy        <= (state_nx != IDLE) && (state_nx != DONE);
      done        <= (state_nx == DONE);
      step        <= state_nx;
    end
  end

endmodule

// File: tb/tb_psram_init_seq.sv
// Directed bench for psram_init_seq: short-delay builds with and without
// QPI entry, mid-command reset, and the default power-up delay.
module tb_psram_init_seq;

  logic       clk = 1'b0;
  logic       rn   [3];
  logic       st   [3];
  logic       ce   [3];
  logic       sclk [3];
  logic [3:0] sio  [3];
  logic [3:0] oe   [3];
  logic       busy [3];
  logic       done [3];
  logic [3:0] step [3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  psram_init_seq #(
    .CLK_FREQ_MHZ(1), .PWRUP_US(10), .GAP_CYCLES(4), .ENTER_QPI(1)
  ) u_qpi (
    .clk(clk), .rst_n(rn[0]), .start(st[0]),
    .mem_ce(ce[0]), .mem_sclk(sclk[0]),
    .mem_sio_out(sio[0]), .mem_sio_oe(oe[0]),
    .busy(busy[0]), .done(done[0]), .step(step[0])
  );

  psram_init_seq #(
    .CLK_FREQ_MHZ(1), .PWRUP_US(10), .GAP_CYCLES(4), .ENTER_QPI(0)
  ) u_spi (
    .clk(clk), .rst_n(rn[1]), .start(st[1]),
    .mem_ce(ce[1]), .mem_sclk(sclk[1]),
    .mem_sio_out(sio[1]), .mem_sio_oe(oe[1]),
    .busy(busy[1]), .done(done[1]), .step(step[1])
  );

  psram_init_seq u_dflt (
    .clk(clk), .rst_n(rn[2]), .start(st[2]),
    .mem_ce(ce[2]), .mem_sclk(sclk[2]),
    .mem_sio_out(sio[2]), .mem_sio_oe(oe[2]),
    .busy(busy[2]), .done(done[2]), .step(step[2])
  );

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse start, then watch ncyc cycles decoding SPI bytes on sio[0]
  task automatic trace(input int s, input int ncyc, input bit repulse,
                       output int dly, output int nwin,
                       output logic [23:0] bytes, output int bad_edge,
                       output int bad_gap, output int done_at,
                       output int bad_inv);
    logic       pce, psclk;
    logic [7:0] b;
    int         edges, gap;
    dly = 0; nwin = 0; bytes = '0; bad_edge = 0; bad_gap = 0;
    done_at = -1; bad_inv = 0;
    pce = 1'b1; psclk = 1'b0; b = '0; edges = 0; gap = 0;
    st[s] = 1'b1;
    @(negedge clk);
    st[s] = 1'b0;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (step[s] == 4'd1) dly++;
      if (done[s] && done_at < 0) done_at = i;
      if (oe[s] !== {3'b000, ~ce[s]}) bad_inv++;
      if (ce[s] && (sclk[s] || sio[s] != 4'd0)) bad_inv++;
      if (busy[s] !== (step[s] >= 4'd1 && step[s] <= 4'd7)) bad_inv++;
      if (done[s] !== (step[s] == 4'd8)) bad_inv++;
      if (!ce[s]) begin
        if (pce) begin
          edges = 0;
          b = '0;
          if (nwin > 0 && gap != 4) bad_gap++;
        end
        if (sclk[s] && !psclk) begin
          b = {b[6:0], sio[s][0]};
          edges++;
        end
      end else begin
        if (!pce) begin
          if (edges != 8) bad_edge++;
          bytes = {bytes[15:0], b};
          nwin++;
          gap = 0;
        end
        gap++;
      end
      pce = ce[s];
      psclk = sclk[s];
      st[s] = repulse && (i == 4);
    end
    st[s] = 1'b0;
  endtask

  int          dly, nwin, bad_edge, bad_gap, done_at, bad_inv, bad, w;
  logic [23:0] bytes;

  initial begin
    for (int i = 0; i < 3; i++) begin
      rn[i] = 1'b0;
      st[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_step", step[0], 0);
    check("rst_ce", ce[0], 1);
    check("rst_sclk", sclk[0], 0);
    check("rst_oe", oe[0], 0);
    check("rst_sio", sio[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    for (int i = 0; i < 3; i++) rn[i] = 1'b1;

    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++)
        if (step[j] != 0 || !ce[j] || sclk[j] || oe[j] != 0 ||
            busy[j] || done[j]) bad++;
    end
    check("idle_hold", bad, 0);

    trace(1, 80, 1'b0, dly, nwin, bytes, bad_edge, bad_gap, done_at, bad_inv);
    check("spi_delay", dly, 10);
    check("spi_windows", nwin, 2);
    check("spi_bytes", bytes, 24'h006699);
    check("spi_edges", bad_edge, 0);
    check("spi_gap", bad_gap, 0);
    check("spi_done_at", done_at, 51);
    check("spi_inv", bad_inv, 0);

    trace(0, 90, 1'b0, dly, nwin, bytes, bad_edge, bad_gap, done_at, bad_inv);
    check("qpi_delay", dly, 10);
    check("qpi_windows", nwin, 3);
    check("qpi_bytes", bytes, 24'h669935);
    check("qpi_edges", bad_edge, 0);
    check("qpi_gap", bad_gap, 0);
    check("qpi_done_at", done_at, 71);
    check("qpi_inv", bad_inv, 0);

    rn[0] = 1'b0;
    @(negedge clk);
    rn[0] = 1'b1;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    w = 0;
    while (step[0] != 4'd4 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("mid_reach_rst", step[0], 4);
    repeat (7) @(negedge clk);
    check("mid_k7_ce", ce[0], 0);
    check("mid_k7_sclk", sclk[0], 1);
    #2 rn[0] = 1'b0;
    #1;
    check("mid_async_ce", ce[0], 1);
    check("mid_async_sclk", sclk[0], 0);
    check("mid_async_step", step[0], 0);
    check("mid_async_oe", oe[0], 0);
    @(negedge clk);
    rn[0] = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (step[0] != 0 || !ce[0] || busy[0]) bad++;
    end
    check("mid_idle_hold", bad, 0);

    trace(0, 90, 1'b1, dly, nwin, bytes, bad_edge, bad_gap, done_at, bad_inv);
    check("re_delay", dly, 10);
    check("re_windows", nwin, 3);
    check("re_bytes", bytes, 24'h669935);
    check("re_done_at", done_at, 71);
    check("re_inv", bad_inv, 0);

    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!done[0] || !ce[0] || sclk[0] || step[0] != 4'd8) bad++;
    end
    check("done_sticky", bad, 0);

    st[2] = 1'b1;
    @(negedge clk);
    st[2] = 1'b0;
    w = 0;
    while (step[2] != 4'd1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("dflt_enter", step[2], 1);
    dly = 0;
    while (step[2] == 4'd1 && dly < 20000) begin
      @(negedge clk);
      dly++;
    end
    check("dflt_delay", dly, 12600);
    check("dflt_next", step[2], 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/psram_init_seq.md
Name: psram_init_seq

Overview:
- Parametrised PSRAM power-up and initialisation sequencer.
- Waits the required power-up delay, then serially issues RSTEN (0x66), RST (0x99) and, optionally, Enter-QPI (0x35) in SPI mode, with CE-high gaps between commands.
- Sits between the board start button and the PSRAM pins. Raises `done` when the memory is ready for the read/write controller.
- Memory clock is clk/2, generated internally.

Parameters:
- CLK_FREQ_MHZ, 84: system clock frequency in MHz.
- PWRUP_US, 150: power-up delay in µs. DELAY_CYCLES = CLK_FREQ_MHZ*PWRUP_US, which must be ≥ 1.
- GAP_CYCLES, 4: clk cycles CE is held high between commands (tCPH). Must be ≥ 1.
- ENTER_QPI, 1: 1 = send 0x35 after RST; 0 = finish after RST.

Ports:
- clk input 1: system clock; all logic on rising edge.
- rst_n input 1: asynchronous active-low reset.
- start input 1: start request; sampled each clk and latched (sticky).
- mem_ce output 1: PSRAM chip enable, active low.
- mem_sclk output 1: PSRAM serial clock.
- mem_sio_out output 4: data to SIO[3:0]. Only bit 0 is used; bits 3:1 are always 0.
- mem_sio_oe output 4: output enables. 4'b0001 while a command is shifting, else 4'b0000.
- busy output 1: high from start acceptance until DONE.
- done output 1: high in DONE; stays high until reset.
- step output 4: current state encoding (debug/LEDs).

Behaviour:
- All outputs are registered.
- Reset values (asynchronous assert, synchronous deassert not required):
  - state IDLE, step 0, mem_ce 1, mem_sclk 0
  - mem_sio_out 0, mem_sio_oe 0
  - busy 0, done 0, start latch 0, all counters 0
- Assertion of rst_n=0 at any time, including mid-command, returns to these values immediately. CE going high aborts the PSRAM command.
- States and step encodings:
  - IDLE 0, DELAY 1, RSTEN 2, GAP1 3, RST 4, GAP2 5, QPI 6, GAP3 7, DONE 8.
- IDLE:
  - Stays here while the start latch is 0.
  - The first clk with start=1 sets the latch. The next cycle enters DELAY with busy=1.
- DELAY:
  - Counter runs 0..DELAY_CYCLES-1. State is DELAY for exactly DELAY_CYCLES cycles, then RSTEN.
  - start is ignored here and in all later states.
- Command states RSTEN/RST/QPI:
  - Phase counter k = 0..15; state lasts exactly 16 cycles.
  - In cycle k: mem_ce=0, mem_sio_oe=0001, mem_sclk=k[0], mem_sio_out[0]=cmd[7-(k>>1)]. MSB first.
  - Data changes only while sclk is 0, so it is stable at each sclk rising edge (8 rising edges per command).
  - After k=15, the next cycle enters the following GAP state.
- GAP states:
  - mem_ce=1, mem_sclk=0, mem_sio_oe=0, mem_sio_out=0, held for exactly GAP_CYCLES cycles.
  - GAP1 → RST.
  - GAP2 → QPI if ENTER_QPI=1, else DONE.
  - GAP3 → DONE.
- DONE: done=1, busy=0, mem_ce=1. Terminal until reset; no re-initialisation on further start.
- Widths:
  - Delay counter is wide enough for DELAY_CYCLES (ceil log2, minimum 1).
  - Gap counter is sized to GAP_CYCLES.
  - No wrap-around occurs; counters clear on state exit.
- Simultaneous events: start asserted in the same cycle rst_n releases is sampled on the first clk edge after release.

Test Plan:
- Reset/idle: rst_n=0 then 1, start=0 for 50 cycles → step=0, mem_ce=1, mem_sclk=0, mem_sio_oe=0, busy=0, done=0 throughout.
- Full sequence, CLK_FREQ_MHZ=1, PWRUP_US=10, GAP_CYCLES=4, ENTER_QPI=1, 1-cycle start pulse:
  - DELAY lasts 10 cycles.
  - Bench decodes bytes 0x66, 0x99, 0x35 on sio[0] at sclk rising edges, 8 edges per CE-low window.
  - CE is high for exactly 4 cycles between windows.
  - done=1 exactly 1+10+3·16+3·4 cycles after the start-latch cycle.
- ENTER_QPI=0: same stimulus → only 0x66 and 0x99 sent; done rises after GAP2; no third CE-low window.
- Reset mid-command: assert rst_n=0 at RST phase k=7 → mem_ce=1 and sclk=0 asynchronously. After release, IDLE persists until a new start, then the full sequence repeats from DELAY.
- Start re-pulsed during DELAY and after DONE → DELAY length unchanged (10 cycles); done stays 1, no further CE activity.
- Default parameters (84 MHz, 150 µs) → DELAY lasts 12600 cycles (check via step transition 1→2).
